// File: rtl/mem_access_unit.sv
// Data-memory initiator: byte/half/word loads and stores over a word-only memory.
// Define MAU_MISALIGN_TRAP_EN to turn misaligned half/word accesses into error responses.
module mem_access_unit #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_we,
  input  logic [31:0]       mem_rdata
);

`ifdef MAU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE, RD, WR, RESP
  } state_e;

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              sgn_q, sgn_d;
  logic [1:0]        off_q, off_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [ADDR_W-1:0] maddr_q, maddr_d;
  logic [31:0]       mwdata_q, mwdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic       mis;
  logic       err_in;
  logic [1:0] off_in;

  function automatic logic [31:0] extract(
    input logic [31:0] w,
    input logic [1:0]  sz,
    input logic [1:0]  off,
    input logic        sg
  );
    logic [31:0] s;
    s = w >> {off, 3'b000};
    unique case (1'b1)
      sz == 2'b00: extract = {{24{sg & s[7]}}, s[7:0]};
      sz == 2'b01: extract = {{16{sg & s[15]}}, s[15:0]};
      default:     extract = w;
    endcase
  endfunction

  function automatic logic [31:0] merge(
    input logic [31:0] w,
    input logic [31:0] d,
    input logic [1:0]  sz,
    input logic [1:0]  off
  );
    logic [31:0] m;
    logic [4:0]  sh;
    m  = (sz == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF;
    sh = {off, 3'b000};
    merge = (w & ~(m << sh)) | ((d & m) << sh);
  endfunction

  assign mis = (req_size == 2'b01 && req_addr[0]) ||
               (req_size == 2'b10 && req_addr[1:0] != 2'b00);
  assign err_in = (req_size == 2'b11) || (TRAP && mis);

  // Without the trap, low bits are forced to the access's natural alignment.
  always_comb begin
    off_in = req_addr[1:0];
    unique case (1'b1)
      req_size == 2'b01: off_in[0] = 1'b0;
      req_size[1]:       off_in = 2'b00;
      default:           off_in = req_addr[1:0];
    endcase
  end

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    size_d   = size_q;
    sgn_d    = sgn_q;
    off_d    = off_q;
    wdata_d  = wdata_q;
    maddr_d  = maddr_q;
    mwdata_d = mwdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          size_d  = req_size;
          sgn_d   = req_signed;
          off_d   = off_in;
          wdata_d = req_wdata;
          if (err_in) begin
            state_d = RESP;
            rdata_d = 32'h0;
            err_d   = 1'b1;
          end else begin
            maddr_d = {req_addr[ADDR_W-1:2], 2'b00};
            if (req_we && req_size == 2'b10) begin
              state_d  = WR;
              mwdata_d = req_wdata;
            end else begin
              state_d = RD;
            end
          end
        end
      end
      RD: begin
        if (we_q) begin
          state_d  = WR;
          mwdata_d = merge(mem_rdata, wdata_q, size_q, off_q);
        end else begin
          state_d = RESP;
          rdata_d = extract(mem_rdata, size_q, off_q, sgn_q);
          err_d   = 1'b0;
        end
      end
      WR: begin
        state_d = RESP;
        rdata_d = 32'h0;
        err_d   = 1'b0;
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      size_q   <= 2'b00;
      sgn_q    <= 1'b0;
      off_q    <= 2'b00;
      wdata_q  <= 32'h0;
      maddr_q  <= '0;
      mwdata_q <= 32'h0;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      size_q   <= size_d;
      sgn_q    <= sgn_d;
      off_q    <= off_d;
      wdata_q  <= wdata_d;
      maddr_q  <= maddr_d;
      mwdata_q <= mwdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign mem_we    = (state_q == WR);
  assign mem_addr  = maddr_q;
  assign mem_wdata = mwdata_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule
